// File: rtl/bp_me_pkg.sv
// bp_me_pkg: memory-NoC header layout and depacketizer state encoding.
`ifndef BP_MEM_NOC_HDR_SLICE
`define BP_MEM_NOC_HDR_SLICE
`define BP_MEM_NOC_HDR_LEN(hdr, cw, lw) hdr[(cw)+(lw)-1:(cw)]
`endif

package bp_me_pkg;
  localparam int mem_noc_flit_width_p        = 64;
  localparam int mem_noc_cord_width_p        = 8;
  localparam int mem_noc_len_width_p         = 4;
  localparam int mem_noc_max_payload_flits_p = 8;

  typedef enum logic [1:0] {
    e_header = 2'd0,
    e_body   = 2'd1,
    e_drain  = 2'd2
  } bp_mem_noc_depkt_state_e;
endpackage

// File: rtl/bsg_two_fifo.sv
// bsg_two_fifo: two-entry registered FIFO; input ready is held low during reset.
module bsg_two_fifo #(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    logic [width_p-1:0] mem_r [2];
    logic               rd_r, wr_r;
    logic [1:0]         cnt_r;
    logic               enq, deq;

    assign ready_o = reset_i & (cnt_r != 2'd2);
    assign v_o     = cnt_r != 2'd0;
    assign data_o  = mem_r[rd_r];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rd_r  <= 1'b0;
            wr_r  <= 1'b0;
            cnt_r <= 2'd0;
        end else begin
            rd_r  <= rd_r ^ deq;
            wr_r  <= wr_r ^ enq;
            cnt_r <= cnt_r + {1'b0, enq} - {1'b0, deq};
        end
    end

    always_ff @(posedge clk_i)
        if (enq) mem_r[wr_r] <= data_i;
endmodule

// File: rtl/bp_mem_noc_depacketizer.sv
// bp_mem_noc_depacketizer: splits memory-NoC packets into a header beat and a payload stream, draining over-length packets.
module bp_mem_noc_depacketizer
  import bp_me_pkg::*;
#(
  parameter int flit_width_p        = mem_noc_flit_width_p,
  parameter int cord_width_p        = mem_noc_cord_width_p,
  parameter int len_width_p         = mem_noc_len_width_p,
  parameter int max_payload_flits_p = mem_noc_max_payload_flits_p
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    link_v_i,
  input  logic [flit_width_p-1:0] link_data_i,
  output logic                    link_ready_and_o,
  output logic                    hdr_v_o,
  output logic [flit_width_p-1:0] hdr_o,
  input  logic                    hdr_ready_and_i,
  output logic                    data_v_o,
  output logic [flit_width_p-1:0] data_o,
  output logic                    data_last_o,
  input  logic                    data_ready_and_i,
  output logic                    len_err_o
);
  localparam logic [len_width_p-1:0] cnt_one = len_width_p'(1);

  bp_mem_noc_depkt_state_e state_r, state_n;
  logic [len_width_p-1:0]  cnt_r, cnt_n, len;
  logic [flit_width_p-1:0] fifo_data;
  logic                    fifo_v, fifo_yumi;
  logic                    hdr_pop, hdr_load, len_bad, body_pop, drain_pop, hdr_start, step;

  bsg_two_fifo #(.width_p(flit_width_p)) fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (link_v_i),
    .data_i  (link_data_i),
    .ready_o (link_ready_and_o),
    .v_o     (fifo_v),
    .data_o  (fifo_data),
    .yumi_i  (fifo_yumi)
  );

  assign len         = `BP_MEM_NOC_HDR_LEN(fifo_data, cord_width_p, len_width_p);
  assign len_bad     = 32'(len) > max_payload_flits_p;
  assign hdr_pop     = (state_r == e_header) & fifo_v & (~hdr_v_o | hdr_ready_and_i);
  assign hdr_load    = hdr_pop & ~len_bad;
  assign data_v_o    = (state_r == e_body) & fifo_v;
  assign data_o      = fifo_data;
  assign data_last_o = (state_r == e_body) & (cnt_r == cnt_one);
  assign body_pop    = data_v_o & data_ready_and_i;
  assign drain_pop   = (state_r == e_drain) & fifo_v;
  assign fifo_yumi   = hdr_pop | body_pop | drain_pop;
  assign hdr_start   = hdr_pop & (len != '0);
  assign step        = body_pop | drain_pop;

  always_comb begin
    state_n = hdr_start ? (len_bad ? e_drain : e_body)
            : (step && cnt_r == cnt_one) ? e_header : state_r;
    cnt_n   = hdr_start ? len : step ? cnt_r - cnt_one : cnt_r;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r   <= e_header;
      cnt_r     <= '0;
      hdr_v_o   <= 1'b0;
      hdr_o     <= '0;
      len_err_o <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      hdr_v_o   <= hdr_load | (hdr_v_o & ~hdr_ready_and_i);
      hdr_o     <= hdr_load ? fifo_data : hdr_o;
      len_err_o <= len_err_o | (hdr_pop & len_bad);
    end
  end
endmodule

// File: tb/tb_bp_mem_noc_depacketizer.sv
// tb_bp_mem_noc_depacketizer: directed vector table, multi-cycle corner sequences and a scoreboarded random stress run.
module tb_bp_mem_noc_depacketizer;
    logic        clk = 1'b0, reset_i = 1'b0;
    logic        link_v_i = 1'b0, hdr_ready_and_i = 1'b0, data_ready_and_i = 1'b0;
    logic [63:0] link_data_i = '0;
    logic        link_ready_and_o, hdr_v_o, data_v_o, data_last_o, len_err_o;
    logic [63:0] hdr_o, data_o;

    int          tests = 0, fails = 0, hdr_beats = 0, data_beats = 0;
    logic [63:0] exp_hdr_q[$];
    logic [64:0] exp_data_q[$];
    logic [64:0] exp_d;
    logic        hdr_stall = 1'b0, data_stall = 1'b0;
    logic [63:0] hdr_hold, data_hold;
    bit          stop_rdy = 0, track_rdy = 0, saw_rdy_low = 0, sent = 0;

    typedef struct {
        logic [3:0] len;
        logic [7:0] cord;
        int         exp_hdrs;
        int         exp_data;
        logic       exp_err;
    } vec_t;
    vec_t vecs[6];

    logic [63:0] h;
    logic [51:0] tg;
    logic [3:0]  rl;
    int          hb, db, n, eh, ed;

    bp_mem_noc_depacketizer dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .link_v_i         (link_v_i),
        .link_data_i      (link_data_i),
        .link_ready_and_o (link_ready_and_o),
        .hdr_v_o          (hdr_v_o),
        .hdr_o            (hdr_o),
        .hdr_ready_and_i  (hdr_ready_and_i),
        .data_v_o         (data_v_o),
        .data_o           (data_o),
        .data_last_o      (data_last_o),
        .data_ready_and_i (data_ready_and_i),
        .len_err_o        (len_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every handshake and the hold-while-stalled rule.
    always @(negedge clk) begin
        if (!reset_i) begin
            hdr_stall  = 1'b0;
            data_stall = 1'b0;
        end else begin
            if (hdr_stall) begin
                check("hdr_hold_v", 64'(hdr_v_o), 64'd1);
                check("hdr_hold_data", hdr_o, hdr_hold);
            end
            if (data_stall) begin
                check("data_hold_v", 64'(data_v_o), 64'd1);
                check("data_hold_data", data_o, data_hold);
            end
            if (hdr_v_o && hdr_ready_and_i) begin
                hdr_beats++;
                if (exp_hdr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL hdr_unexpected: got %h expected no header", hdr_o);
                end else check("hdr", hdr_o, exp_hdr_q.pop_front());
            end
            if (data_v_o && data_ready_and_i) begin
                data_beats++;
                if (exp_data_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL data_unexpected: got %h expected no payload", data_o);
                end else begin
                    exp_d = exp_data_q.pop_front();
                    check("data", data_o, exp_d[63:0]);
                    check("data_last", 64'(data_last_o), 64'(exp_d[64]));
                end
            end
            hdr_stall  = hdr_v_o & ~hdr_ready_and_i;
            hdr_hold   = hdr_o;
            data_stall = data_v_o & ~data_ready_and_i;
            data_hold  = data_o;
            if (track_rdy && link_v_i && !link_ready_and_o) saw_rdy_low = 1;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic gap(input int k);
        link_v_i = 1'b0;
        repeat (k) tick();
    endtask

    task automatic send_flit(input logic [63:0] f);
        int   tries = 0;
        logic ok;
        link_v_i    = 1'b1;
        link_data_i = f;
        forever begin
            @(negedge clk);
            ok = link_ready_and_o;
            tick();
            if (ok) break;
            if (++tries > 2000) begin
                $display("FAIL link_accept: got no acceptance after %0d cycles expected acceptance", tries);
                $fatal(1);
            end
        end
        link_v_i = 1'b0;
    endtask

    task automatic send_pkt(input logic [3:0] len, input logic [7:0] cord, input logic [51:0] tag, input bit gaps);
        logic [63:0] hf, d;
        hf = {tag, len, cord};
        if (len <= 4'd8) exp_hdr_q.push_back(hf);
        if (gaps) gap($urandom_range(0, 2));
        send_flit(hf);
        for (int i = 0; i < int'(len); i++) begin
            d = {~tag, 4'(i), 8'hd0};
            if (len <= 4'd8) exp_data_q.push_back({i == int'(len) - 1, d});
            if (gaps) gap($urandom_range(0, 2));
            send_flit(d);
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_hdr_q.size() != 0 || exp_data_q.size() != 0) && k < 5000) begin
            tick();
            k++;
        end
        repeat (4) tick();
        check({name, "_hdr_left"}, 64'(exp_hdr_q.size()), 64'd0);
        check({name, "_data_left"}, 64'(exp_data_q.size()), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'd3,  8'h21, 1, 3, 1'b0};
        vecs[1] = '{4'd0,  8'h22, 1, 0, 1'b0};
        vecs[2] = '{4'd8,  8'h23, 1, 8, 1'b0};
        vecs[3] = '{4'd9,  8'h24, 0, 0, 1'b1};
        vecs[4] = '{4'd15, 8'h25, 0, 0, 1'b1};
        vecs[5] = '{4'd1,  8'h26, 1, 1, 1'b1};

        // reset values
        repeat (3) tick();
        @(negedge clk);
        check("rst_link_ready", 64'(link_ready_and_o), 64'd0);
        check("rst_hdr_v", 64'(hdr_v_o), 64'd0);
        check("rst_hdr", hdr_o, 64'd0);
        check("rst_data_v", 64'(data_v_o), 64'd0);
        check("rst_data_last", 64'(data_last_o), 64'd0);
        check("rst_len_err", 64'(len_err_o), 64'd0);
        tick();
        reset_i = 1'b1;
        hdr_ready_and_i = 1'b1;
        data_ready_and_i = 1'b1;

        // single-flit packet with header latency
        h = {52'h1, 4'd1, 8'h12};
        exp_hdr_q.push_back(h);
        exp_data_q.push_back({1'b1, 64'hAAAA});
        link_v_i = 1'b1;
        link_data_i = h;
        @(negedge clk);
        check("sf_ready", 64'(link_ready_and_o), 64'd1);
        tick();
        link_data_i = 64'hAAAA;
        @(negedge clk);
        check("sf_hdr_v_early", 64'(hdr_v_o), 64'd0);
        check("sf_data_v_early", 64'(data_v_o), 64'd0);
        tick();
        link_v_i = 1'b0;
        @(negedge clk);
        check("sf_hdr_v", 64'(hdr_v_o), 64'd1);
        check("sf_cord", 64'(hdr_o[7:0]), 64'h12);
        check("sf_data_v", 64'(data_v_o), 64'd1);
        check("sf_data", data_o, 64'hAAAA);
        check("sf_last", 64'(data_last_o), 64'd1);
        tick();
        @(negedge clk);
        check("sf_hdr_v_done", 64'(hdr_v_o), 64'd0);
        check("sf_data_v_done", 64'(data_v_o), 64'd0);
        tick();

        // vector table
        for (int i = 0; i < 6; i++) begin
            hb = hdr_beats;
            db = data_beats;
            send_pkt(vecs[i].len, vecs[i].cord, 52'(100 + i), 0);
            drain("vec");
            check("vec_hdrs", 64'(hdr_beats - hb), 64'(vecs[i].exp_hdrs));
            check("vec_data", 64'(data_beats - db), 64'(vecs[i].exp_data));
            check("vec_err", 64'(len_err_o), 64'(vecs[i].exp_err));
        end

        // back-to-back, link never stalls
        hb = hdr_beats;
        db = data_beats;
        track_rdy = 1;
        saw_rdy_low = 0;
        send_pkt(4'd3, 8'h31, 52'h300, 0);
        send_pkt(4'd0, 8'h32, 52'h301, 0);
        drain("b2b");
        track_rdy = 0;
        check("b2b_ready_low", 64'(saw_rdy_low), 64'd0);
        check("b2b_hdrs", 64'(hdr_beats - hb), 64'd2);
        check("b2b_data", 64'(data_beats - db), 64'd3);

        // reset mid-packet with flits still buffered
        h = {52'h400, 4'd5, 8'h41};
        exp_hdr_q.push_back(h);
        exp_data_q.push_back({1'b0, ~52'h400, 4'd0, 8'hd0});
        exp_data_q.push_back({1'b0, ~52'h400, 4'd1, 8'hd0});
        send_flit(h);
        send_flit({~52'h400, 4'd0, 8'hd0});
        send_flit({~52'h400, 4'd1, 8'hd0});
        gap(1);
        data_ready_and_i = 1'b0;
        send_flit({~52'h400, 4'd2, 8'hd0});
        send_flit({~52'h400, 4'd3, 8'hd0});
        check("mid_data_left", 64'(exp_data_q.size()), 64'd0);
        reset_i = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 64'(link_ready_and_o), 64'd0);
        tick();
        reset_i = 1'b1;
        data_ready_and_i = 1'b1;
        @(negedge clk);
        check("mid_hdr_v", 64'(hdr_v_o), 64'd0);
        check("mid_hdr", hdr_o, 64'd0);
        check("mid_data_v", 64'(data_v_o), 64'd0);
        check("mid_data_last", 64'(data_last_o), 64'd0);
        check("mid_len_err", 64'(len_err_o), 64'd0);
        check("mid_ready", 64'(link_ready_and_o), 64'd1);
        tick();
        hb = hdr_beats;
        db = data_beats;
        send_pkt(4'd1, 8'h42, 52'h401, 0);
        drain("mid_new");
        check("mid_new_hdrs", 64'(hdr_beats - hb), 64'd1);
        check("mid_new_data", 64'(data_beats - db), 64'd1);

        // over-length packet is drained and flagged
        send_flit({52'h77, 4'd12, 8'h51});
        @(negedge clk);
        check("ol_err_before_pop", 64'(len_err_o), 64'd0);
        tick();
        @(negedge clk);
        check("ol_err_after_pop", 64'(len_err_o), 64'd1);
        check("ol_hdr_v", 64'(hdr_v_o), 64'd0);
        hb = hdr_beats;
        db = data_beats;
        tick();
        for (int i = 0; i < 12; i++) send_flit({52'h78, 4'(i), 8'h00});
        gap(4);
        check("ol_no_hdr", 64'(hdr_beats - hb), 64'd0);
        check("ol_no_data", 64'(data_beats - db), 64'd0);
        send_pkt(4'd1, 8'h52, 52'h79, 0);
        drain("ol_legal");
        check("ol_legal_hdrs", 64'(hdr_beats - hb), 64'd1);
        check("ol_legal_data", 64'(data_beats - db), 64'd1);
        check("ol_err_sticky", 64'(len_err_o), 64'd1);

        // header backpressure with two queued packets
        hb = hdr_beats;
        db = data_beats;
        hdr_ready_and_i = 1'b0;
        track_rdy = 1;
        saw_rdy_low = 0;
        sent = 0;
        fork
            begin
                send_pkt(4'd2, 8'h61, 52'h600, 0);
                send_pkt(4'd2, 8'h62, 52'h601, 0);
                sent = 1;
            end
        join_none
        repeat (10) tick();
        @(negedge clk);
        check("bp_data_first", 64'(data_beats - db), 64'd2);
        check("bp_hdr_none", 64'(hdr_beats - hb), 64'd0);
        check("bp_hdr_v", 64'(hdr_v_o), 64'd1);
        check("bp_hdr", hdr_o, {52'h600, 4'd2, 8'h61});
        check("bp_ready_low", 64'(saw_rdy_low), 64'd1);
        check("bp_ready_now", 64'(link_ready_and_o), 64'd0);
        tick();
        hdr_ready_and_i = 1'b1;
        track_rdy = 0;
        n = 0;
        while (!sent && n < 2000) begin
            tick();
            n++;
        end
        check("bp_sent", 64'(sent), 64'd1);
        drain("bp");
        check("bp_hdrs", 64'(hdr_beats - hb), 64'd2);
        check("bp_data", 64'(data_beats - db), 64'd4);

        // random stress
        hb = hdr_beats;
        db = data_beats;
        eh = 0;
        ed = 0;
        stop_rdy = 0;
        fork
            begin
                for (int p = 0; p < 1000; p++) begin
                    rl = 4'($urandom_range(0, 11));
                    tg = {20'($urandom), 32'($urandom)};
                    if (rl <= 4'd8) begin
                        eh++;
                        ed += int'(rl);
                    end
                    send_pkt(rl, 8'($urandom), tg, 1);
                end
                stop_rdy = 1;
            end
            begin
                while (!stop_rdy) begin
                    tick();
                    hdr_ready_and_i = $urandom_range(0, 3) != 0;
                    data_ready_and_i = $urandom_range(0, 3) != 0;
                end
            end
        join
        hdr_ready_and_i = 1'b1;
        data_ready_and_i = 1'b1;
        drain("rnd");
        check("rnd_hdrs", 64'(hdr_beats - hb), 64'(eh));
        check("rnd_data", 64'(data_beats - db), 64'(ed));
        check("rnd_err", 64'(len_err_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
